// File: rtl/gate_vector_checker.sv
// Sequences the four {A,B} input combinations into a 2-input gate under test,
// samples its output O after a settle delay, and reports per-vector mismatches.
module gate_vector_checker #(
    parameter int unsigned SETTLE = 4,
    parameter logic [3:0]  EXPECT = 4'b1110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       O,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     r_state, w_state;
    logic [1:0] r_idx, w_idx;
    logic [3:0] r_cnt, w_cnt;
    logic       r_a, w_a;
    logic       r_b, w_b;
    logic       r_busy, w_busy;
    logic       r_done, w_done;
    logic       r_pass, w_pass;
    logic [3:0] r_fail_vec, w_fail_vec;
    logic [2:0] r_err_count, w_err_count;
    logic       w_mismatch;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        if (v >= 3'd4) begin
            sat_inc = 3'd4;
        end else begin
            sat_inc = v + 3'd1;
        end
    endfunction

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_cnt       = r_cnt;
        w_a         = r_a;
        w_b         = r_b;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_pass      = r_pass;
        w_fail_vec  = r_fail_vec;
        w_err_count = r_err_count;
        w_mismatch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state     = S_DRIVE;
                    w_idx       = 2'd0;
                    w_fail_vec  = 4'd0;
                    w_err_count = 3'd0;
                    w_pass      = 1'b0;
                    w_a         = 1'b0;
                    w_b         = 1'b0;
                    w_busy      = 1'b1;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_DRIVE: begin
                {w_a, w_b} = r_idx;
                w_cnt      = SETTLE_LOAD;
                w_state    = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state = S_SAMPLE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            S_SAMPLE: begin
                w_mismatch = (O != EXPECT[r_idx]);
                if (w_mismatch) begin
                    w_fail_vec[r_idx] = 1'b1;
                    w_err_count       = sat_inc(r_err_count);
                end else begin
                    w_err_count = r_err_count;
                end
                // The next vector is presented on entry to DRIVE so A/B are valid throughout DRIVE.
                if (r_idx != 2'd3) begin
                    w_idx      = r_idx + 2'd1;
                    {w_a, w_b} = r_idx + 2'd1;
                    w_state    = S_DRIVE;
                end else begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_pass  = (w_err_count == 3'd0);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_idx   = 2'd0;
                w_cnt   = 4'd0;
                w_a     = 1'b0;
                w_b     = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_cnt       <= 4'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_vec  <= 4'd0;
            r_err_count <= 3'd0;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_cnt       <= w_cnt;
            r_a         <= w_a;
            r_b         <= w_b;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_pass      <= w_pass;
            r_fail_vec  <= w_fail_vec;
            r_err_count <= w_err_count;
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_vec  = r_fail_vec;
    assign err_count = r_err_count;

endmodule
